// File: rtl/mfm_word_encoder_pkg.sv
// Shared MFM constants, FSM state type and the reference byte-to-word encoding.
package mfm_pkg;

   localparam logic [7:0]  MFM_GAP_BYTE  = 8'h4E;
   localparam logic [15:0] MFM_SYNC_MASK = 16'hFFDF;
   localparam logic [15:0] MFM_A1_SYNC   = 16'h4489;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } mfm_state_e;

   // Data bit di lands on bit 2i; clock ci on bit 2i+1 is set only between two zero data bits.
   function automatic logic [15:0] mfm_encode(input logic prev, input logic [7:0] data);
      logic [8:0]  d;
      logic [15:0] w;
      d = {prev, data};
      w = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         w[2*i]   = d[i];
         w[2*i+1] = ~(d[i+1] | d[i]);
      end
      return w;
   endfunction

endpackage

// File: rtl/mfm_word_encoder_if.sv
// Byte-side and word-side handshake bundle of the MFM word encoder.
interface mfm_word_encoder_if #(
   parameter int CNT_W = 13
);
   logic             track_sync;
   logic             gap_en;
   logic [7:0]       byte_data;
   logic             byte_mark;
   logic             byte_valid;
   logic             byte_ready;
   logic [15:0]      mfm_word;
   logic             word_valid;
   logic             word_ready;
   logic [CNT_W-1:0] word_idx;
   logic             track_end;
   logic [7:0]       underrun_cnt;

   modport master (
      output track_sync, gap_en, byte_data, byte_mark, byte_valid, word_ready,
      input  byte_ready, mfm_word, word_valid, word_idx, track_end, underrun_cnt
   );

   modport slave (
      input  track_sync, gap_en, byte_data, byte_mark, byte_valid, word_ready,
      output byte_ready, mfm_word, word_valid, word_idx, track_end, underrun_cnt
   );
endinterface

// File: rtl/mfm_word_encoder_byte_enc.sv
// Combinational MFM encoder for one byte; mark bytes lose clock c2 (missing-clock sync).
module mfm_byte_enc
   import mfm_pkg::*;
(
   input  logic        i_prev,
   input  logic [7:0]  i_byte,
   input  logic        i_mark,
   output logic [15:0] o_word
);

   logic [15:0] w_raw;

   assign w_raw  = mfm_encode(i_prev, i_byte);
   assign o_word = i_mark ? (w_raw & MFM_SYNC_MASK) : w_raw;

endmodule

// File: rtl/mfm_word_encoder.sv
// Track-framed MFM word encoder: byte handshake in, single registered 16-bit word out.
module mfm_word_encoder
   import mfm_pkg::*;
#(
   parameter int         WORDS_PER_TRACK = 5208,
   parameter logic [7:0] GAP_BYTE        = MFM_GAP_BYTE,
   parameter int         CNT_W           = 13
)(
   input  logic            clk5,
   input  logic            rst_n,
   mfm_word_encoder_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_TRACK - 1);
   localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

   mfm_state_e       r_state, w_state_n;
   logic [15:0]      r_word, w_word_n;
   logic             r_valid, w_valid_n;
   logic [CNT_W-1:0] r_idx, w_idx_n;
   logic [7:0]       r_uc, w_uc_n;
   logic             r_prev, w_prev_n;

   logic             w_final, w_take, w_byte_ready, w_load_byte, w_load_gap;
   logic [7:0]       w_enc_byte;
   logic             w_enc_mark;
   logic [15:0]      w_enc_word;

   // Last word of the track is sitting in the register: nothing may follow it.
   assign w_final      = r_valid && (r_idx == LAST_IDX);
   assign w_take       = r_valid && bus.word_ready;
   assign w_byte_ready = (r_state == ST_RUN) && !bus.track_sync && !w_final
                         && (!r_valid || bus.word_ready);
   assign w_load_byte  = w_byte_ready && bus.byte_valid;
   assign w_load_gap   = w_byte_ready && !bus.byte_valid && bus.gap_en;
   assign w_enc_byte   = bus.byte_valid ? bus.byte_data : GAP_BYTE;
   assign w_enc_mark   = bus.byte_valid && bus.byte_mark;

   mfm_byte_enc u_enc (
      .i_prev (r_prev),
      .i_byte (w_enc_byte),
      .i_mark (w_enc_mark),
      .o_word (w_enc_word)
   );

   always_comb begin
      w_state_n = r_state;
      w_word_n  = r_word;
      w_valid_n = r_valid;
      w_idx_n   = r_idx;
      w_uc_n    = r_uc;
      w_prev_n  = r_prev;
      if (bus.track_sync) begin
         w_valid_n = 1'b0;
         w_prev_n  = 1'b0;
         w_idx_n   = '0;
         w_uc_n    = '0;
         w_state_n = ST_RUN;
      end else if (r_state == ST_RUN) begin
         if (w_take)
            w_idx_n = r_idx + IDX_ONE;
         if (w_load_byte || w_load_gap) begin
            w_word_n  = w_enc_word;
            w_valid_n = 1'b1;
            w_prev_n  = w_enc_byte[0];
         end else if (w_take) begin
            w_valid_n = 1'b0;
         end
         if (w_load_gap && (r_uc != 8'hFF))
            w_uc_n = r_uc + 8'd1;
         if (w_take && w_final)
            w_state_n = ST_IDLE;
      end
   end

   always_ff @(posedge clk5 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_word  <= '0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_uc    <= '0;
         r_prev  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_word  <= w_word_n;
         r_valid <= w_valid_n;
         r_idx   <= w_idx_n;
         r_uc    <= w_uc_n;
         r_prev  <= w_prev_n;
      end
   end

   assign bus.byte_ready   = w_byte_ready;
   assign bus.mfm_word     = r_word;
   assign bus.word_valid   = r_valid;
   assign bus.word_idx     = r_idx;
   assign bus.underrun_cnt = r_uc;
   assign bus.track_end    = (r_state == ST_RUN) && !bus.track_sync && w_take && w_final;

endmodule

// File: tb/tb_mfm_word_encoder.sv
// Randomized and directed bench for mfm_word_encoder against a cycle-level behavioural model.
module tb_mfm_word_encoder;

   localparam int WPT = 300;
   localparam int CW  = 9;

   logic clk5  = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk5 = ~clk5;

   mfm_word_encoder_if #(.CNT_W(CW)) bus ();

   mfm_word_encoder #(
      .WORDS_PER_TRACK (WPT),
      .GAP_BYTE        (8'h4E),
      .CNT_W           (CW)
   ) u_dut (
      .clk5  (clk5),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int tend_seen = 0;

   bit          m_run  = 1'b0;
   bit          m_have = 1'b0;
   bit          m_prev = 1'b0;
   logic [15:0] m_word = 16'h0000;
   int          m_idx  = 0;
   int          m_uc   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Clock bit is 1 exactly when the two surrounding data bits are both 0.
   function automatic logic [15:0] ref_word(input bit prev, input logic [7:0] b, input bit mark);
      int ext;
      logic [15:0] w;
      ext = (int'(prev) << 8) | int'(b);
      w = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         if (((ext >> i) & 1) != 0) w = w | (16'h0001 << (2 * i));
         if (((ext >> i) & 3) == 0) w = w | (16'h0001 << (2 * i + 1));
      end
      if (mark) w = w & ~16'h0020;
      return w;
   endfunction

   task automatic cyc(input bit ts, input bit gap, input logic [7:0] bd,
                      input bit bm, input bit bv, input bit wr);
      bit e_rdy, e_tend, take, last;
      @(negedge clk5);
      bus.track_sync = ts;
      bus.gap_en     = gap;
      bus.byte_data  = bd;
      bus.byte_mark  = bm;
      bus.byte_valid = bv;
      bus.word_ready = wr;
      #1;
      last   = m_have && (m_idx == WPT - 1);
      take   = m_have && wr;
      e_rdy  = m_run && !ts && !last && (!m_have || wr);
      e_tend = m_run && !ts && take && last;
      chk("byte_ready", 32'(bus.byte_ready), 32'(e_rdy));
      chk("track_end", 32'(bus.track_end), 32'(e_tend));
      if (bus.track_end) tend_seen++;
      if (ts) begin
         m_have = 1'b0; m_prev = 1'b0; m_idx = 0; m_uc = 0; m_run = 1'b1;
      end else if (m_run) begin
         if (take) m_idx++;
         if (e_rdy && bv) begin
            m_word = ref_word(m_prev, bd, bm); m_have = 1'b1; m_prev = bd[0];
         end else if (e_rdy && gap) begin
            m_word = ref_word(m_prev, 8'h4E, 1'b0); m_have = 1'b1; m_prev = 1'b0;
            if (m_uc < 255) m_uc++;
         end else if (take) begin
            m_have = 1'b0;
         end
         if (take && last) begin
            m_run = 1'b0; m_have = 1'b0;
         end
      end
      @(posedge clk5);
      #1;
      chk("word_valid", 32'(bus.word_valid), 32'(m_have));
      chk("mfm_word", 32'(bus.mfm_word), 32'(m_word));
      chk("word_idx", 32'(bus.word_idx), 32'(m_idx));
      chk("underrun_cnt", 32'(bus.underrun_cnt), 32'(m_uc));
   endtask

   initial begin
      bus.track_sync = 1'b0;
      bus.gap_en     = 1'b0;
      bus.byte_data  = 8'h00;
      bus.byte_mark  = 1'b0;
      bus.byte_valid = 1'b1;
      bus.word_ready = 1'b0;
      #23;
      chk("rst_word", 32'(bus.mfm_word), 32'h0);
      chk("rst_valid", 32'(bus.word_valid), 32'h0);
      chk("rst_idx", 32'(bus.word_idx), 32'h0);
      chk("rst_uc", 32'(bus.underrun_cnt), 32'h0);
      chk("rst_ready", 32'(bus.byte_ready), 32'h0);
      chk("rst_tend", 32'(bus.track_end), 32'h0);
      bus.byte_valid = 1'b0;
      @(negedge clk5);
      rst_n = 1'b1;

      cyc(1, 0, 8'h00, 0, 0, 1);
      cyc(0, 0, 8'h00, 0, 1, 1);
      chk("t1_word", 32'(bus.mfm_word), 32'hAAAA);
      chk("t1_idx", 32'(bus.word_idx), 32'h0);
      cyc(0, 0, 8'hFF, 0, 1, 1);
      chk("t2_ff", 32'(bus.mfm_word), 32'h5555);
      cyc(0, 0, 8'h00, 0, 1, 1);
      chk("t2_00", 32'(bus.mfm_word), 32'h2AAA);
      cyc(0, 0, 8'hA1, 1, 1, 1);
      chk("t3_a1_mark", 32'(bus.mfm_word), 32'h4489);
      cyc(0, 0, 8'h00, 0, 1, 1);
      cyc(0, 0, 8'hA1, 0, 1, 1);
      chk("t3_a1_data", 32'(bus.mfm_word), 32'h44A9);
      cyc(0, 0, 8'h00, 0, 1, 1);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 8'h00, 0, 0, 1);
         chk("t4_gap", 32'(bus.mfm_word), 32'h9254);
      end
      chk("t4_uc", 32'(bus.underrun_cnt), 32'd3);

      cyc(0, 0, 8'h3C, 0, 1, 1);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, 8'h5A, 0, 1, 0);
         chk("t5_hold", 32'(bus.mfm_word), 32'(ref_word(1'b0, 8'h3C, 1'b0)));
      end
      cyc(0, 0, 8'h5A, 0, 1, 1);
      chk("t5_next", 32'(bus.mfm_word), 32'(ref_word(1'b0, 8'h5A, 1'b0)));
      cyc(0, 0, 8'h00, 0, 0, 1);
      chk("t5_drain", 32'(bus.word_valid), 32'h0);

      cyc(0, 0, 8'h11, 0, 1, 1);
      cyc(1, 0, 8'h22, 0, 1, 1);
      chk("t6_sync_valid", 32'(bus.word_valid), 32'h0);
      chk("t6_sync_idx", 32'(bus.word_idx), 32'h0);

      tend_seen = 0;
      for (int k = 0; k < WPT + 5; k++) cyc(0, 1, 8'h00, 0, 0, 1);
      chk("sat_uc", 32'(bus.underrun_cnt), 32'd255);
      chk("end_tend_once", 32'(tend_seen), 32'd1);
      chk("end_valid", 32'(bus.word_valid), 32'h0);
      chk("end_idx", 32'(bus.word_idx), 32'(WPT));

      for (int n = 0; n < 3000; n++) begin
         bit ts;
         ts = (!m_run && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 999) == 0);
         cyc(ts, $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
